alu_seq: RTL and testbench

Parametrised, sequential successor of the datapath ALU. It registers the result and the condition codes, and adds a ready/start/done handshake. It also adds a carry flag that persists between operations and feeds ADC/SBC/RSC, optional flag update per operation, and a multi-cycle shift-add multiplier. It sits in the execute stage between the operand latches and the register-file write-back and status register.

---
 rtl/alu_seq.sv | 169 ++++++++++++++++
 tb/tb_alu_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU for the execute stage: registered result and condition flags,
// start/ready/done handshake, persistent carry and an iterative shift-add multiplier.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_flags,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             n,
  output logic             v,
  output logic             z
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'h0;
  localparam logic [3:0] OP_XOR   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_RSB   = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_ADC   = 4'h5;
  localparam logic [3:0] OP_SBC   = 4'h6;
  localparam logic [3:0] OP_RSC   = 4'h7;
  localparam logic [3:0] OP_OR    = 4'h8;
  localparam logic [3:0] OP_MOVB  = 4'h9;
  localparam logic [3:0] OP_BIC   = 4'hA;
  localparam logic [3:0] OP_MVN   = 4'hB;
  localparam logic [3:0] OP_PASSA = 4'hC;
  localparam logic [3:0] OP_AP4   = 4'hD;
  localparam logic [3:0] OP_MUL   = 4'hE;
  localparam logic [3:0] OP_ILL   = 4'hF;

  typedef enum logic {ST_IDLE, ST_MULT} state_e;

  state_e           state_q;
  logic             ready_q, done_q, c_q, n_q, v_q, z_q, sf_q;
  logic [WIDTH-1:0] result_q, acc_q, a_sh_q, b_sh_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] alu_x, alu_y, alu_res;
  logic [WIDTH:0]   alu_sum;
  logic             alu_cin, alu_arith, alu_logic, alu_c, alu_v;
  logic [WIDTH-1:0] acc_d;

  // Single-cycle datapath: every arithmetic op is x + y + cin on a WIDTH+1 bit adder
  always_comb begin
    alu_x     = a;
    alu_y     = b;
    alu_cin   = 1'b0;
    alu_arith = 1'b0;
    alu_logic = 1'b0;
    alu_res   = '0;
    unique case (op)
      OP_AND:   begin alu_res = a & b;  alu_logic = 1'b1; end
      OP_XOR:   begin alu_res = a ^ b;  alu_logic = 1'b1; end
      OP_OR:    begin alu_res = a | b;  alu_logic = 1'b1; end
      OP_MOVB:  begin alu_res = b;      alu_logic = 1'b1; end
      OP_BIC:   begin alu_res = a & ~b; alu_logic = 1'b1; end
      OP_MVN:   begin alu_res = ~b;     alu_logic = 1'b1; end
      OP_PASSA: begin alu_res = a;      alu_logic = 1'b1; end
      OP_SUB:   begin alu_y = ~b; alu_cin = 1'b1; alu_arith = 1'b1; end
      OP_RSB:   begin alu_x = b; alu_y = ~a; alu_cin = 1'b1; alu_arith = 1'b1; end
      OP_ADD:   begin alu_arith = 1'b1; end
      OP_ADC:   begin alu_cin = c_q; alu_arith = 1'b1; end
      OP_SBC:   begin alu_y = ~b; alu_cin = c_q; alu_arith = 1'b1; end
      OP_RSC:   begin alu_x = b; alu_y = ~a; alu_cin = c_q; alu_arith = 1'b1; end
      OP_AP4:   begin alu_y = WIDTH'(4); alu_arith = 1'b1; end
      default:  alu_res = '0;
    endcase
    alu_sum = {1'b0, alu_x} + {1'b0, alu_y} + (WIDTH + 1)'(alu_cin);
    if (alu_arith) alu_res = alu_sum[WIDTH-1:0];
    alu_c = alu_sum[WIDTH];
    // carry into the MSB recovered from the MSB sum bit
    alu_v = (alu_x[WIDTH-1] ^ alu_y[WIDTH-1] ^ alu_sum[WIDTH-1]) ^ alu_sum[WIDTH];
  end

  always_comb begin
    acc_d = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      sf_q     <= 1'b0;
      acc_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              a_sh_q  <= a;
              b_sh_q  <= b;
              sf_q    <= set_flags;
              acc_q   <= '0;
              cnt_q   <= CW'(WIDTH);
              ready_q <= 1'b0;
              state_q <= ST_MULT;
            end else begin
              done_q <= 1'b1;
              if (op == OP_ILL) begin
                result_q <= '0;
              end else begin
                result_q <= alu_res;
                if (set_flags) begin
                  n_q <= alu_res[WIDTH-1];
                  z_q <= (alu_res == '0);
                  if (alu_arith) begin
                    c_q <= alu_c;
                    v_q <= alu_v;
                  end else if (alu_logic) begin
                    c_q <= 1'b0;
                  end
                end
              end
            end
          end
        end
        ST_MULT: begin
          acc_q  <= acc_d;
          a_sh_q <= a_sh_q << 1;
          b_sh_q <= b_sh_q >> 1;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q <= acc_d;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= ST_IDLE;
            if (sf_q) begin
              n_q <= acc_d[WIDTH-1];
              z_q <= (acc_d == '0);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;
  assign c      = c_q;
  assign n      = n_q;
  assign v      = v_q;
  assign z      = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 32-bit and an 8-bit instance checked against an arithmetic
// reference model, directed corner cases followed by random operations.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        st32, sf32, rdy32, dn32, c32, n32, v32, z32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, r32;
  logic        st8, sf8, rdy8, dn8, c8, n8, v8, z8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, r8;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(st32), .op(op32), .a(a32), .b(b32),
    .set_flags(sf32), .ready(rdy32), .done(dn32), .result(r32),
    .c(c32), .n(n32), .v(v32), .z(z32));

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .op(op8), .a(a8), .b(b8),
    .set_flags(sf8), .ready(rdy8), .done(dn8), .result(r8),
    .c(c8), .n(n8), .v(v8), .z(z8));

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] mr [2];
  logic        mc [2], mn [2], mv [2], mz [2];

  function automatic int wd(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  // Reference: flags from plain signed/unsigned integer arithmetic
  function automatic void model(input int w, input logic [3:0] op, input logic [63:0] a, b,
                                input logic sf, input logic ci, ni, vi, zi,
                                output logic [63:0] r, output logic co, no, vo, zo);
    logic [63:0] msk;
    longint ua, ub, sa, sb, us, ss, smin, smax;
    bit is_arith, is_sub, is_log;
    msk  = (64'd1 << w) - 64'd1;
    ua   = longint'(a & msk);
    ub   = longint'(b & msk);
    sa   = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb   = b[w-1] ? ub - (longint'(1) << w) : ub;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -smax - 1;
    us = 0; ss = 0; r = '0;
    is_arith = 1'b0; is_sub = 1'b0; is_log = 1'b0;
    case (op)
      4'h0: begin r = a & b & msk;          is_log = 1'b1; end
      4'h1: begin r = (a ^ b) & msk;        is_log = 1'b1; end
      4'h8: begin r = (a | b) & msk;        is_log = 1'b1; end
      4'h9: begin r = b & msk;              is_log = 1'b1; end
      4'hA: begin r = a & ~b & msk;         is_log = 1'b1; end
      4'hB: begin r = ~b & msk;             is_log = 1'b1; end
      4'hC: begin r = a & msk;              is_log = 1'b1; end
      4'h2: begin us = ua - ub; ss = sa - sb; is_arith = 1'b1; is_sub = 1'b1; end
      4'h3: begin us = ub - ua; ss = sb - sa; is_arith = 1'b1; is_sub = 1'b1; end
      4'h4: begin us = ua + ub; ss = sa + sb; is_arith = 1'b1; end
      4'h5: begin us = ua + ub + longint'(ci); ss = sa + sb + longint'(ci); is_arith = 1'b1; end
      4'h6: begin us = ua - ub - longint'(!ci); ss = sa - sb - longint'(!ci);
                  is_arith = 1'b1; is_sub = 1'b1; end
      4'h7: begin us = ub - ua - longint'(!ci); ss = sb - sa - longint'(!ci);
                  is_arith = 1'b1; is_sub = 1'b1; end
      4'hD: begin us = ua + 4; ss = sa + 4; is_arith = 1'b1; end
      4'hE: r = 64'(ua * ub) & msk;
      default: r = '0;
    endcase
    if (is_arith) r = 64'(us) & msk;
    co = ci; no = ni; vo = vi; zo = zi;
    if (sf && op != 4'hF) begin
      no = r[w-1];
      zo = (r == 64'd0);
      if (is_arith) begin
        co = is_sub ? (us >= 0) : (us > longint'(msk));
        vo = (ss < smin) || (ss > smax);
      end
      if (is_log) co = 1'b0;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic s, input logic [3:0] o,
                       input logic [63:0] av, input logic [63:0] bv, input logic sf);
    if (i == 0) begin st32 = s; op32 = o; a32 = av[31:0]; b32 = bv[31:0]; sf32 = sf; end
    else        begin st8  = s; op8  = o; a8  = av[7:0];  b8  = bv[7:0];  sf8  = sf; end
  endtask

  task automatic check_state(input int i, input string tag, input logic rdy, input logic dn);
    logic [63:0] r;
    logic [3:0]  f;
    logic        ro, dno;
    if (i == 0) begin r = 64'(r32); f = {c32, n32, v32, z32}; ro = rdy32; dno = dn32; end
    else        begin r = 64'(r8);  f = {c8, n8, v8, z8};     ro = rdy8;  dno = dn8;  end
    check({tag, "_result"}, r, mr[i]);
    check({tag, "_flags"}, 64'(f), 64'({mc[i], mn[i], mv[i], mz[i]}));
    check({tag, "_ready"}, 64'(ro), 64'(rdy));
    check({tag, "_done"}, 64'(dno), 64'(dn));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mr[i] = '0; mc[i] = 1'b0; mn[i] = 1'b0; mv[i] = 1'b0; mz[i] = 1'b0;
    end
  endtask

  // Accept one op; for MUL check the busy window, inject an ignored start, then the result
  task automatic run_op(input int i, input string tag, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b, input logic sf);
    logic [63:0] nr;
    logic        nc, nn, nv, nz;
    int          w;
    w = wd(i);
    @(negedge clk);
    drive(i, 1'b1, op, a, b, sf);
    @(posedge clk); #1;
    drive(i, 1'b0, op, a, b, sf);
    model(w, op, a, b, sf, mc[i], mn[i], mv[i], mz[i], nr, nc, nn, nv, nz);
    if (op == 4'hE) begin
      for (int k = 0; k < w; k++) begin
        check_state(i, {tag, "_busy"}, 1'b0, 1'b0);
        if (k == 2) drive(i, 1'b1, 4'h4, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        if (k == 4) drive(i, 1'b0, 4'h4, a, b, sf);
        @(posedge clk); #1;
      end
    end
    mr[i] = nr; mc[i] = nc; mn[i] = nn; mv[i] = nv; mz[i] = nz;
    check_state(i, tag, 1'b1, 1'b1);
  endtask

  task automatic idle(input int i, input string tag);
    @(posedge clk); #1;
    check_state(i, tag, 1'b1, 1'b0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [3:0]  rop;
    int          ri;

    rst_n = 1'b0;
    drive(0, 1'b0, 4'h0, 64'd0, 64'd0, 1'b0);
    drive(1, 1'b0, 4'h0, 64'd0, 64'd0, 1'b0);
    model_reset();
    #12;
    check_state(0, "reset32", 1'b1, 1'b0);
    check_state(1, "reset8", 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, "add_wrap", 4'h4, 64'hFFFF_FFFF, 64'd1, 1'b1);
    idle(0, "add_pulse");

    run_op(0, "sub_ovf", 4'h2, 64'h8000_0000, 64'd1, 1'b1);
    run_op(0, "adc_carry", 4'h5, 64'd0, 64'd0, 1'b1);
    run_op(0, "and_noflags", 4'h0, 64'hF0, 64'h0F, 1'b0);
    idle(0, "and_pulse");

    run_op(1, "add8_ovf", 4'h4, 64'h7F, 64'h7F, 1'b1);
    run_op(1, "sub8_ovf", 4'h2, 64'h80, 64'h01, 1'b1);
    run_op(1, "mul8_ff", 4'hE, 64'h0F, 64'h11, 1'b1);
    run_op(1, "mul8_zero", 4'hE, 64'h10, 64'h10, 1'b1);
    idle(1, "mul8_pulse");

    // Reset in the middle of a multiply
    @(negedge clk);
    drive(1, 1'b1, 4'hE, 64'h23, 64'h45, 1'b1);
    @(posedge clk); #1;
    drive(1, 1'b0, 4'hE, 64'h23, 64'h45, 1'b1);
    check_state(1, "mulrst_busy", 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state(1, "mulrst8", 1'b1, 1'b0);
    check_state(0, "mulrst32", 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1, "mulrst_idle");

    run_op(0, "set_flags", 4'h2, 64'd3, 64'd5, 1'b1);
    run_op(0, "illegal", 4'hF, 64'd5, 64'd3, 1'b1);
    idle(0, "illegal_pulse");
    run_op(0, "mul32", 4'hE, 64'h1234_5678, 64'h9ABC_DEF1, 1'b1);
    run_op(0, "ap4", 4'hD, 64'h7FFF_FFFD, 64'd0, 1'b1);

    for (int k = 0; k < 160; k++) begin
      ri  = $urandom_range(0, 1);
      rop = 4'($urandom_range(0, 15));
      if (ri == 0 && rop == 4'hE && $urandom_range(0, 2) != 0) rop = 4'h5;
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rb = 64'd0;
      run_op(ri, "rand", rop, ra, rb, 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 3) == 0) idle(ri, "rand_idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
